// File: rtl/fetch_ctrl.sv
// fetch_ctrl - fetch-stage sequencer for the RV32I pipeline.
//
// Drives the PC unit (pc_write, pc_src, tgt) and the instruction-memory
// request, and generates IF/ID and ID/EX stall/flush controls for load-use
// hazards, taken branches, jumps and halts. A redirect that arrives while a
// fetch is still outstanding is parked in tgt_q/kind_q until that fetch
// is granted.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req/gnt      instruction fetch request / grant handshake
//   id_load_use       load-use hazard detected in ID
//   ex_br_taken       taken conditional branch in EX
//   ex_jump           JAL/JALR in EX
//   ex_halt           ecall/ebreak in EX
//   ex_target         redirect target from EX
//   resume            leave HALT
//   pc_write, pc_src  PC unit controls (00 pc+4, 01 branch, 10 jump)
//   tgt               redirect target to the PC unit
//   if_id_write       IF/ID capture enable
//   if_id_flush       IF/ID bubble (overrides if_id_write)
//   id_ex_flush       ID/EX bubble
//   halted            high while in HALT
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | normal fetch; redirects with a grant are applied immediately
// REDIR | branch/jump waiting for the wrong-path fetch to be granted
// DRAIN | halt waiting for the wrong-path fetch to be granted
// HALT  | fetch stopped, pipeline held in bubbles until resume

module fetch_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  input  logic            imem_gnt,
  input  logic            id_load_use,
  input  logic            ex_br_taken,
  input  logic            ex_jump,
  input  logic            ex_halt,
  input  logic [XLEN-1:0] ex_target,
  input  logic            resume,
  output logic            pc_write,
  output logic [1:0]      pc_src,
  output logic [XLEN-1:0] tgt,
  output logic            if_id_write,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic            halted
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_REDIR = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [1:0] SRC_SEQ  = 2'b00;
  localparam logic [1:0] SRC_BR   = 2'b01;
  localparam logic [1:0] SRC_JMP  = 2'b10;

  logic [1:0]      state_q, state_d;
  logic [1:0]      kind_q, kind_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [1:0]      redir_kind;

  // Jump wins over a simultaneous taken branch.
  assign redir_kind = ex_jump ? SRC_JMP : SRC_BR;

  // The parked target is only meaningful while waiting out the old fetch.
  assign tgt = (state_q == ST_REDIR || state_q == ST_DRAIN) ? tgt_q : ex_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      kind_q  <= SRC_BR;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    tgt_d       = tgt_q;
    imem_req    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = SRC_SEQ;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    halted      = 1'b0;

    case (state_q)
      ST_RUN: begin
        imem_req = 1'b1;
        if (ex_halt) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (imem_gnt) begin
            pc_write = 1'b1;
            pc_src   = SRC_JMP;
            state_d  = ST_HALT;
          end else begin
            tgt_d   = ex_target;
            kind_d  = SRC_JMP;
            state_d = ST_DRAIN;
          end
        end else if (ex_br_taken || ex_jump) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (imem_gnt) begin
            pc_write = 1'b1;
            pc_src   = redir_kind;
          end else begin
            tgt_d   = ex_target;
            kind_d  = redir_kind;
            state_d = ST_REDIR;
          end
        end else if (id_load_use) begin
          // Freeze PC and IF/ID; a grant this cycle is simply refetched.
          id_ex_flush = 1'b1;
        end else begin
          pc_write    = imem_gnt;
          if_id_write = imem_gnt;
          if_id_flush = !imem_gnt;
        end
      end

      ST_REDIR, ST_DRAIN: begin
        imem_req    = 1'b1;
        if_id_flush = 1'b1;
        if (imem_gnt) begin
          pc_write = 1'b1;
          pc_src   = kind_q;
          state_d  = (state_q == ST_REDIR) ? ST_RUN : ST_HALT;
        end
      end

      default: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        halted      = 1'b1;
        if (resume) state_d = ST_RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl - directed self-checking bench for fetch_ctrl.
// Inputs change just after the falling edge; outputs are sampled 1 time unit
// later, well away from the rising edge where state advances.

module tb_fetch_ctrl;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            imem_req;
  logic            imem_gnt = 1'b0;
  logic            id_load_use = 1'b0;
  logic            ex_br_taken = 1'b0;
  logic            ex_jump = 1'b0;
  logic            ex_halt = 1'b0;
  logic [XLEN-1:0] ex_target = '0;
  logic            resume = 1'b0;
  logic            pc_write;
  logic [1:0]      pc_src;
  logic [XLEN-1:0] tgt;
  logic            if_id_write;
  logic            if_id_flush;
  logic            id_ex_flush;
  logic            halted;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_ctrl #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_gnt    (imem_gnt),
    .id_load_use (id_load_use),
    .ex_br_taken (ex_br_taken),
    .ex_jump     (ex_jump),
    .ex_halt     (ex_halt),
    .ex_target   (ex_target),
    .resume      (resume),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .tgt         (tgt),
    .if_id_write (if_id_write),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Control vector: {imem_req, pc_write, pc_src[1:0], if_id_write,
  //                  if_id_flush, id_ex_flush, halted}
  localparam logic [7:0] C_RESET   = 8'b1_0_00_0_1_0_0; // RUN, no grant
  localparam logic [7:0] C_SEQ     = 8'b1_1_00_1_0_0_0;
  localparam logic [7:0] C_BR_GNT  = 8'b1_1_01_0_1_1_0;
  localparam logic [7:0] C_JMP_GNT = 8'b1_1_10_0_1_1_0;
  localparam logic [7:0] C_RED_NG  = 8'b1_0_00_0_1_1_0; // redirect/halt, no grant
  localparam logic [7:0] C_WAIT    = 8'b1_0_00_0_1_0_0; // REDIR/DRAIN waiting
  localparam logic [7:0] C_WAIT_J  = 8'b1_1_10_0_1_0_0; // REDIR/DRAIN grant, kind 10
  localparam logic [7:0] C_WAIT_B  = 8'b1_1_01_0_1_0_0; // REDIR grant, kind 01
  localparam logic [7:0] C_LU      = 8'b1_0_00_0_0_1_0;
  localparam logic [7:0] C_HALT    = 8'b0_0_00_0_1_1_1;

  task automatic drive(input logic gnt, input logic lu, input logic br,
                       input logic jmp, input logic hlt,
                       input logic [XLEN-1:0] t, input logic res);
    imem_gnt    = gnt;
    id_load_use = lu;
    ex_br_taken = br;
    ex_jump     = jmp;
    ex_halt     = hlt;
    ex_target   = t;
    resume      = res;
  endtask

  // Sample outputs, compare, then advance to the next falling edge.
  task automatic step(input string tag, input logic [7:0] exp_ctl,
                      input logic [XLEN-1:0] exp_tgt);
    logic [7:0] obs_ctl;
    #1;
    obs_ctl = {imem_req, pc_write, pc_src, if_id_write, if_id_flush,
               id_ex_flush, halted};
    n_checks++;
    assert (obs_ctl === exp_ctl) else begin
      n_fail++;
      $error("FAIL %s ctl: observed %b required %b", tag, obs_ctl, exp_ctl);
    end
    n_checks++;
    assert (tgt === exp_tgt) else begin
      n_fail++;
      $error("FAIL %s tgt: observed %h required %h", tag, tgt, exp_tgt);
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    step("reset", C_RESET, 32'h0);
    rst_n = 1'b1;

    // Straight-line
    drive(1, 0, 0, 0, 0, 32'h0, 0);
    step("seq0", C_SEQ, 32'h0);
    step("seq1", C_SEQ, 32'h0);
    step("seq2", C_SEQ, 32'h0);

    // Taken branch with grant: applied same cycle, stays in RUN
    drive(1, 0, 1, 0, 0, 32'h40, 0);
    step("br_gnt", C_BR_GNT, 32'h40);
    drive(1, 0, 0, 0, 0, 32'h0, 0);
    step("br_after", C_SEQ, 32'h0);

    // Jump and branch together with grant: jump wins
    drive(1, 0, 1, 1, 0, 32'h80, 0);
    step("br_jmp_gnt", C_JMP_GNT, 32'h80);

    // Jump without grant -> REDIR, held target survives ex_target change
    drive(0, 0, 0, 1, 0, 32'h100, 0);
    step("jmp_nogrant", C_RED_NG, 32'h100);
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    step("redir_w1", C_WAIT, 32'h100);
    drive(0, 1, 1, 0, 1, 32'h0, 1);   // EX/ID/resume inputs ignored in REDIR
    step("redir_w2_ign", C_WAIT, 32'h100);
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    step("redir_w3", C_WAIT, 32'h100);
    drive(1, 0, 0, 0, 0, 32'h0, 0);
    step("redir_gnt", C_WAIT_J, 32'h100);
    step("redir_back", C_SEQ, 32'h0);

    // Load-use for one cycle with grant
    drive(1, 1, 0, 0, 0, 32'h0, 0);
    step("load_use", C_LU, 32'h0);
    drive(1, 0, 0, 0, 0, 32'h0, 0);
    step("lu_after", C_SEQ, 32'h0);

    // Halt without grant -> DRAIN -> grant -> HALT -> resume
    drive(0, 0, 0, 0, 1, 32'h24, 0);
    step("halt_nogrant", C_RED_NG, 32'h24);
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    step("drain_w1", C_WAIT, 32'h24);
    drive(1, 0, 0, 0, 0, 32'h0, 0);
    step("drain_gnt", C_WAIT_J, 32'h24);
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    step("halted0", C_HALT, 32'h0);
    drive(1, 1, 1, 1, 1, 32'h0, 0);   // everything but resume ignored
    step("halted1", C_HALT, 32'h0);
    drive(0, 0, 0, 0, 0, 32'h0, 1);
    step("halt_resume", C_HALT, 32'h0);
    drive(1, 0, 0, 0, 0, 32'h0, 0);
    step("resumed", C_SEQ, 32'h0);

    // Halt and branch together with grant: halt path, straight to HALT
    drive(1, 0, 1, 0, 1, 32'h80, 0);
    step("halt_prio", C_JMP_GNT, 32'h80);
    drive(0, 0, 0, 0, 0, 32'h0, 1);
    step("halt_prio_h", C_HALT, 32'h0);
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    step("resume_wait", C_RESET, 32'h0);

    // Branch without grant -> REDIR with kind 01
    drive(0, 0, 1, 0, 0, 32'h60, 0);
    step("br_nogrant", C_RED_NG, 32'h60);
    drive(1, 0, 0, 0, 0, 32'h4, 0);
    step("redir_br_gnt", C_WAIT_B, 32'h60);

    // Async reset while in REDIR discards the pending redirect
    drive(0, 0, 1, 0, 0, 32'h55, 0);
    step("br_nogrant2", C_RED_NG, 32'h55);
    drive(0, 0, 0, 0, 0, 32'h11, 0);
    step("redir_hold", C_WAIT, 32'h55);
    rst_n = 1'b0;
    step("rst_in_redir", C_RESET, 32'h11);
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 0, 32'h11, 0);
    step("post_rst", C_SEQ, 32'h11);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage sequencer for the RV32I pipeline. It drives the program counter's `pc_write` and `pc_src` controls and the shared redirect target, and handshakes with instruction memory. It also generates the IF/ID and ID/EX stall and flush controls for load-use hazards, taken branches, jumps and halts (`ecall`/`ebreak`). A redirect that arrives while a fetch is still outstanding is held internally until that fetch completes.

## Interface
- `XLEN`, 32, datapath/address width
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request for current PC; once high, held high until `imem_gnt`
- `imem_gnt`  in  1  fetch accepted/completed this cycle; valid only while `imem_req`=1
- `id_load_use`  in  1  load-use hazard detected in ID
- `ex_br_taken`  in  1  conditional branch in EX resolved taken
- `ex_jump`  in  1  JAL/JALR in EX
- `ex_halt`  in  1  ecall/ebreak in EX
- `ex_target`  in  XLEN  redirect target from EX (for halt: PC of halting instruction + 4)
- `resume`  in  1  leave HALT
- `pc_write`  out  1  to PC unit
- `pc_src`  out  2  to PC unit: 00 pc+4, 01 branch, 10 jump; 11 never driven
- `tgt`  out  XLEN  wired to both PC-unit `branch_target` and `jump_target`
- `if_id_write`  out  1  IF/ID capture enable
- `if_id_flush`  out  1  IF/ID bubble; overrides `if_id_write`
- `id_ex_flush`  out  1  ID/EX bubble
- `halted`  out  1  high in HALT

## Operation
- State register uses four states: RUN, REDIR, DRAIN, HALT.
- Pending registers: `kind_q` (01 or 10) and `tgt_q` (XLEN).
- `tgt` = `tgt_q` in REDIR/DRAIN, otherwise `ex_target` (combinational).
- Outputs are combinational from state and inputs.
- Any output not listed for a case is 0.

RUN (`imem_req`=1). Conditions are evaluated in this priority order:
- **`ex_halt`**
  - Assert `if_id_flush`=1 and `id_ex_flush`=1.
  - If `imem_gnt`: `pc_write`=1, `pc_src`=10, go to HALT.
  - Otherwise: `tgt_q`<=`ex_target`, `kind_q`<=10, go to DRAIN.
- **`ex_br_taken` or `ex_jump`**
  - Assert `if_id_flush`=1 and `id_ex_flush`=1.
  - Kind is 10 if `ex_jump`, else 01; `ex_jump` wins if both are asserted.
  - If `imem_gnt`: `pc_write`=1, `pc_src`=kind, stay in RUN.
  - Otherwise: latch `tgt_q` and `kind_q`, go to REDIR.
- **`id_load_use`**
  - `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1.
  - `imem_gnt` is ignored for PC advance; the same PC is refetched.
- **Otherwise**
  - `pc_write`=`imem_gnt`, `pc_src`=00, `if_id_write`=`imem_gnt`.
  - `if_id_flush`=!`imem_gnt`, so a bubble enters IF/ID while the fetch waits.

REDIR / DRAIN (`imem_req`=1, old wrong-path fetch still outstanding):
- `if_id_flush`=1 every cycle.
- All EX inputs and `id_load_use` are ignored; the upstream stages hold bubbles.
- On `imem_gnt`: `pc_write`=1, `pc_src`=`kind_q`, `tgt`=`tgt_q`.
  - From REDIR, go to RUN.
  - From DRAIN, go to HALT.

HALT:
- `imem_req`=0, `pc_write`=0, `if_id_flush`=1, `id_ex_flush`=1, `halted`=1.
- `resume`=1: go to RUN next cycle and fetch from the held PC.
- `resume` is ignored in all other states.

## Timing
- Reset (async assert, sync deassert upstream):
  - state=RUN, `tgt_q`=0, `kind_q`=01.
  - Outputs therefore follow RUN rules: `imem_req`=1, `halted`=0.
  - Instruction memory ignores `imem_req` while `rst_n`=0.
- Reset mid-REDIR/DRAIN/HALT: pending state is discarded; the first fetch after reset is PC 0.
- Redirect with `imem_gnt` the same cycle: the new PC is visible at the next edge, so the redirect penalty is 2 bubbles (IF/ID and ID/EX flushed).
- Redirect without `imem_gnt`: PC updates on the edge after the cycle `imem_gnt`=1 in REDIR. The penalty is 2 + wait cycles.
- Load-use: exactly one ID/EX bubble per cycle `id_load_use` is asserted. PC and IF/ID are frozen.
- `imem_req` never drops while a request is outstanding. It drops only in HALT, which is entered only after a grant.
- HALT → RUN: `imem_req` rises the cycle after `resume`.

## Test plan
- **Straight-line:** `imem_gnt`=1 constantly → `pc_write`=1 and `pc_src`=00 every cycle, with no flushes.
- **Taken branch with grant:** `ex_br_taken`=1, `ex_target`=0x40, `imem_gnt`=1 → same cycle `pc_write`=1, `pc_src`=01, `tgt`=0x40, both flushes asserted; state stays RUN.
- **Jump without grant:** `ex_jump`=1, `ex_target`=0x100, `imem_gnt`=0 for 3 cycles then 1.
  - → REDIR for 4 cycles with `if_id_flush`=1 throughout.
  - → On the grant cycle, `pc_src`=10 and `tgt`=0x100 even though `ex_target` has changed to 0x0.
  - → Returns to RUN.
- **Load-use:** `id_load_use`=1 for 1 cycle with `imem_gnt`=1 → `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1; normal operation resumes the next cycle.
- **Halt/resume:**
  - `ex_halt`=1, `ex_target`=0x24, `imem_gnt`=0, then grant after 2 cycles → DRAIN, then `pc_write` with `tgt`=0x24, then HALT with `halted`=1 and `imem_req`=0.
  - `resume` → RUN and `imem_req`=1 the next cycle.
- **Priority and reset:**
  - `ex_halt` and `ex_br_taken` asserted together → halt path taken.
  - Async `rst_n` low during REDIR → immediately RUN, `halted`=0, pending target cleared.
